// File: rtl/mem_stage_pkg.sv
// mem_stage_pkg: shared constants and helpers for the MEM pipeline stage.
//   - MIPS opcode constants for the memory-access and jal instructions.
//   - Bit ranges of the rs/rt/rd register fields in an instruction word.
//   - Enumerated load/store kinds and decode helpers used by mem_stage.
package mem_stage_pkg;

  localparam logic [5:0] OP_LW  = 6'b100011;
  localparam logic [5:0] OP_LH  = 6'b100001;
  localparam logic [5:0] OP_LHU = 6'b100101;
  localparam logic [5:0] OP_LB  = 6'b100000;
  localparam logic [5:0] OP_LBU = 6'b100100;
  localparam logic [5:0] OP_SW  = 6'b101011;
  localparam logic [5:0] OP_SH  = 6'b101001;
  localparam logic [5:0] OP_SB  = 6'b101000;
  localparam logic [5:0] OP_JAL = 6'b000011;

  localparam int RS_HI = 25;
  localparam int RS_LO = 21;
  localparam int RT_HI = 20;
  localparam int RT_LO = 16;
  localparam int RD_HI = 15;
  localparam int RD_LO = 11;

  typedef enum logic [2:0] {
    LD_NONE,
    LD_W,
    LD_H,
    LD_HU,
    LD_B,
    LD_BU
  } load_e;

  typedef enum logic [1:0] {
    ST_NONE,
    ST_W,
    ST_H,
    ST_B
  } store_e;

  function automatic load_e decode_load(input logic [5:0] op);
    case (op)
      OP_LW:   return LD_W;
      OP_LH:   return LD_H;
      OP_LHU:  return LD_HU;
      OP_LB:   return LD_B;
      OP_LBU:  return LD_BU;
      default: return LD_NONE;
    endcase
  endfunction

  function automatic store_e decode_store(input logic [5:0] op);
    case (op)
      OP_SW:   return ST_W;
      OP_SH:   return ST_H;
      OP_SB:   return ST_B;
      default: return ST_NONE;
    endcase
  endfunction

endpackage

// File: rtl/mem_stage_if.sv
// mem_stage_if: bundle of EX/MEM inputs, forwarding outputs and MEM/WB
// register outputs of the MEM stage.
//   slave  : used by mem_stage (consumes M_*, drives M_Pass/M_rt/MW_*).
//   master : used by the surrounding pipeline (drives M_*, reads results).
interface mem_stage_if;
  logic [31:0] M_instruc;
  logic [31:0] M_AluRe;
  logic [31:0] M_WTDM;
  logic [4:0]  M_WRA;
  logic [31:0] M_PC;
  logic [31:0] M_W_WRD;
  logic        PassSrcM;
  logic [31:0] M_Pass;
  logic [4:0]  M_rt;
  logic [31:0] MW_instruc;
  logic [31:0] MW_AluRe;
  logic [31:0] MW_DMRD;
  logic [4:0]  MW_WRA;
  logic [31:0] MW_PC;

  modport slave (
    input  M_instruc, M_AluRe, M_WTDM, M_WRA, M_PC, M_W_WRD, PassSrcM,
    output M_Pass, M_rt, MW_instruc, MW_AluRe, MW_DMRD, MW_WRA, MW_PC
  );

  modport master (
    output M_instruc, M_AluRe, M_WTDM, M_WRA, M_PC, M_W_WRD, PassSrcM,
    input  M_Pass, M_rt, MW_instruc, MW_AluRe, MW_DMRD, MW_WRA, MW_PC
  );
endinterface

// File: rtl/mem_stage_dm_ram.sv
// dm_ram: data memory, DM_WORDS x 32 bits, organised as four byte lanes.
//   clk   : rising-edge clock
//   reset : synchronous active-low clear of every word (wins over writes)
//   addr  : word index
//   be    : per-lane write enable (be[3] = bits 31:24)
//   wdata : write data, lanes taken from their own bit positions
//   rdata : asynchronous read of the addressed word
module dm_ram #(
  parameter int DM_WORDS = 1024,
  parameter int DM_AW    = 10
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [DM_AW-1:0] addr,
  input  logic [3:0]       be,
  input  logic [31:0]      wdata,
  output logic [31:0]      rdata
);

  // One array per byte lane keeps each lane's write port independent.
  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_lane
      logic [7:0] lane_mem [DM_WORDS];

      always_ff @(posedge clk) begin
        if (!reset) begin
          for (int w = 0; w < DM_WORDS; w++) begin
            lane_mem[w] <= '0;
          end
        end else if (be[gi]) begin
          lane_mem[addr] <= wdata[gi*8 +: 8];
        end
      end

      assign rdata[gi*8 +: 8] = lane_mem[addr];
    end
  endgenerate

endmodule

// File: rtl/mem_stage.sv
// mem_stage: MEM stage of the 5-stage MIPS pipeline.
//   clk   : pipeline clock, rising edge
//   reset : synchronous active-low reset (clears MEM/WB register and memory)
//   bus   : mem_stage_if.slave
//     M_*   EX/MEM register contents and W-stage write data for forwarding
//     M_Pass forwarding value (PC+8 for jal, else ALU result), combinational
//     M_rt   rt field of the instruction in MEM
//     MW_*   registered MEM/WB bundle, MW_DMRD holds the extended load data
module mem_stage
  import mem_stage_pkg::*;
#(
  parameter int DM_WORDS = 1024,
  parameter int DM_AW    = 10
) (
  input logic       clk,
  input logic       reset,
  mem_stage_if.slave bus
);

  logic [5:0]       opcode;
  logic [DM_AW-1:0] word_idx;
  logic [1:0]       offset;
  logic [31:0]      store_data;
  load_e            ld_kind;
  store_e           st_kind;
  logic [3:0]       be;
  logic [31:0]      wdata;
  logic [31:0]      rdata;
  logic [15:0]      ld_half;
  logic [7:0]       ld_byte;
  logic [31:0]      ld_data;

  assign opcode     = bus.M_instruc[31:26];
  // Upper address bits are dropped, so out-of-range addresses wrap.
  assign word_idx   = bus.M_AluRe[DM_AW+1:2];
  assign offset     = bus.M_AluRe[1:0];
  assign store_data = bus.PassSrcM ? bus.M_W_WRD : bus.M_WTDM;
  assign ld_kind    = decode_load(opcode);
  assign st_kind    = decode_store(opcode);

  // Store lane steering: replicate the data so every lane sees it and let
  // the byte enables pick where it lands.
  always_comb begin
    be    = 4'b0000;
    wdata = store_data;
    case (st_kind)
      ST_W: begin
        be    = 4'b1111;
        wdata = store_data;
      end
      ST_H: begin
        be    = offset[1] ? 4'b1100 : 4'b0011;
        wdata = {2{store_data[15:0]}};
      end
      ST_B: begin
        be    = 4'b0001 << offset;
        wdata = {4{store_data[7:0]}};
      end
      default: begin
        be    = 4'b0000;
        wdata = store_data;
      end
    endcase
  end

  dm_ram #(
    .DM_WORDS(DM_WORDS),
    .DM_AW   (DM_AW)
  ) u_dm_ram (
    .clk  (clk),
    .reset(reset),
    .addr (word_idx),
    .be   (be),
    .wdata(wdata),
    .rdata(rdata)
  );

  // Load lane extraction and extension.
  assign ld_half = offset[1] ? rdata[31:16] : rdata[15:0];
  assign ld_byte = rdata[{offset, 3'b000} +: 8];

  always_comb begin
    ld_data = '0;
    case (ld_kind)
      LD_W:    ld_data = rdata;
      LD_H:    ld_data = {{16{ld_half[15]}}, ld_half};
      LD_HU:   ld_data = {16'h0000, ld_half};
      LD_B:    ld_data = {{24{ld_byte[7]}}, ld_byte};
      LD_BU:   ld_data = {24'h000000, ld_byte};
      default: ld_data = '0;
    endcase
  end

  assign bus.M_Pass = (opcode == OP_JAL) ? bus.M_PC + 32'd8 : bus.M_AluRe;
  assign bus.M_rt   = bus.M_instruc[RT_HI:RT_LO];

  // MEM/WB pipeline register; the stage never stalls.
  always_ff @(posedge clk) begin
    if (!reset) begin
      bus.MW_instruc <= '0;
      bus.MW_AluRe   <= '0;
      bus.MW_DMRD    <= '0;
      bus.MW_WRA     <= '0;
      bus.MW_PC      <= '0;
    end else begin
      bus.MW_instruc <= bus.M_instruc;
      bus.MW_AluRe   <= bus.M_AluRe;
      bus.MW_DMRD    <= ld_data;
      bus.MW_WRA     <= bus.M_WRA;
      bus.MW_PC      <= bus.M_PC;
    end
  end

endmodule

// File: tb/tb_mem_stage.sv
// tb_mem_stage: directed-vector bench for mem_stage.
module tb_mem_stage;
  import mem_stage_pkg::*;

  logic clk;
  logic reset;
  int   total;
  int   bad;

  mem_stage_if bus ();

  mem_stage #(
    .DM_WORDS(1024),
    .DM_AW   (10)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] mk(input logic [5:0] op, input logic [4:0] rt);
    return {op, 5'd1, rt, 16'h0000};
  endfunction

  // Present one instruction in MEM.
  task automatic drive(input logic [5:0] op, input logic [31:0] addr,
                       input logic [31:0] wtdm, input logic [31:0] wwrd,
                       input logic pass, input logic [4:0] wra,
                       input logic [31:0] pc);
    bus.M_instruc = mk(op, wra);
    bus.M_AluRe   = addr;
    bus.M_WTDM    = wtdm;
    bus.M_W_WRD   = wwrd;
    bus.PassSrcM  = pass;
    bus.M_WRA     = wra;
    bus.M_PC      = pc;
  endtask

  // Advance one clock; outputs are sampled 1 time unit after the edge.
  task automatic step();
    @(posedge clk);
    #1;
    $display("txn t=%0t rst=%b op=%b addr=%h sd=%h -> MW_DMRD=%h MW_AluRe=%h",
             $time, reset, bus.M_instruc[31:26], bus.M_AluRe,
             bus.PassSrcM ? bus.M_W_WRD : bus.M_WTDM, bus.MW_DMRD, bus.MW_AluRe);
  endtask

  // Perform a load, then compare the registered load data.
  task automatic load_chk(input string name, input logic [5:0] op,
                          input logic [31:0] addr, input logic [31:0] exp);
    drive(op, addr, 32'h0, 32'h0, 1'b0, 5'd3, 32'h0000_1000);
    step();
    total++;
    if (bus.MW_DMRD !== exp) begin
      bad++;
      $display("FAIL %s: MW_DMRD got %h want %h", name, bus.MW_DMRD, exp);
    end
  endtask

  task automatic test_reset();
    reset = 1'b0;
    drive(OP_LW, 32'h0000_0010, 32'h0, 32'h0, 1'b0, 5'd7, 32'h0000_0400);
    for (int c = 0; c < 2; c++) begin
      step();
      total++;
      if (bus.MW_instruc !== 32'h0 || bus.MW_AluRe !== 32'h0 || bus.MW_DMRD !== 32'h0 ||
          bus.MW_WRA !== 5'd0 || bus.MW_PC !== 32'h0) begin
        bad++;
        $display("FAIL reset_mw: got instr=%h alu=%h dmrd=%h wra=%h pc=%h want all 0",
                 bus.MW_instruc, bus.MW_AluRe, bus.MW_DMRD, bus.MW_WRA, bus.MW_PC);
      end
    end
    reset = 1'b1;
    load_chk("reset_lw10", OP_LW, 32'h0000_0010, 32'h0);
    total++;
    if (bus.MW_AluRe !== 32'h10 || bus.MW_WRA !== 5'd3 || bus.MW_PC !== 32'h1000 ||
        bus.MW_instruc !== mk(OP_LW, 5'd3)) begin
      bad++;
      $display("FAIL mw_pass: got alu=%h wra=%h pc=%h instr=%h want 10/3/1000/%h",
               bus.MW_AluRe, bus.MW_WRA, bus.MW_PC, bus.MW_instruc, mk(OP_LW, 5'd3));
    end
  endtask

  task automatic test_sw_lw();
    drive(OP_SW, 32'h0000_0008, 32'hDEAD_BEEF, 32'h0, 1'b0, 5'd4, 32'h0000_2000);
    step();
    total++;
    if (bus.MW_DMRD !== 32'h0 || bus.MW_PC !== 32'h2000 || bus.MW_WRA !== 5'd4) begin
      bad++;
      $display("FAIL sw_mw: got dmrd=%h pc=%h wra=%h want 0/2000/4",
               bus.MW_DMRD, bus.MW_PC, bus.MW_WRA);
    end
    load_chk("sw_lw", OP_LW, 32'h0000_0008, 32'hDEAD_BEEF);
  endtask

  task automatic test_lanes();
    drive(OP_SW, 32'h0000_0040, 32'h1122_3344, 32'h0, 1'b0, 5'd0, 32'h0);
    step();
    drive(OP_SB, 32'h0000_0042, 32'h0000_00AA, 32'h0, 1'b0, 5'd0, 32'h0);
    step();
    load_chk("sb_word", OP_LW, 32'h0000_0040, 32'h11AA_3344);
    load_chk("lb_off2", OP_LB, 32'h0000_0042, 32'hFFFF_FFAA);
    load_chk("lbu_off2", OP_LBU, 32'h0000_0042, 32'h0000_00AA);
    load_chk("lb_off3", OP_LB, 32'h0000_0043, 32'h0000_0011);
    load_chk("lbu_off0", OP_LBU, 32'h0000_0040, 32'h0000_0044);
    drive(OP_SH, 32'h0000_0040, 32'h1234_8001, 32'h0, 1'b0, 5'd0, 32'h0);
    step();
    load_chk("sh_word", OP_LW, 32'h0000_0040, 32'h11AA_8001);
    load_chk("lh_off0", OP_LH, 32'h0000_0040, 32'hFFFF_8001);
    load_chk("lhu_off0", OP_LHU, 32'h0000_0040, 32'h0000_8001);
    load_chk("lh_off2", OP_LH, 32'h0000_0042, 32'h0000_11AA);
    // Half store with offset[0] set still targets the upper half.
    drive(OP_SH, 32'h0000_0043, 32'h0000_F00D, 32'h0, 1'b0, 5'd0, 32'h0);
    step();
    load_chk("sh_off3", OP_LW, 32'h0000_0040, 32'hF00D_8001);
    load_chk("lh_off3", OP_LH, 32'h0000_0043, 32'hFFFF_F00D);
  endtask

  task automatic test_forward();
    drive(OP_SW, 32'h0000_0080, 32'h0000_0001, 32'h5A5A_5A5A, 1'b1, 5'd0, 32'h0);
    step();
    load_chk("fwd_wwrd", OP_LW, 32'h0000_0080, 32'h5A5A_5A5A);
    drive(OP_SW, 32'h0000_0084, 32'h0000_0001, 32'h5A5A_5A5A, 1'b0, 5'd0, 32'h0);
    step();
    load_chk("fwd_wtdm", OP_LW, 32'h0000_0084, 32'h0000_0001);
  endtask

  task automatic test_jal();
    drive(OP_JAL, 32'h0000_0007, 32'h0, 32'h0, 1'b0, 5'd31, 32'h0000_3010);
    #1;
    total++;
    if (bus.M_Pass !== 32'h0000_3018) begin
      bad++;
      $display("FAIL jal_pass: got %h want 00003018", bus.M_Pass);
    end
    step();
    total++;
    if (bus.MW_DMRD !== 32'h0 || bus.MW_PC !== 32'h3010 || bus.MW_WRA !== 5'd31) begin
      bad++;
      $display("FAIL jal_mw: got dmrd=%h pc=%h wra=%h want 0/3010/1f",
               bus.MW_DMRD, bus.MW_PC, bus.MW_WRA);
    end
    // addu rd=9: opcode 0, rt=0x0a, funct 100001.
    bus.M_instruc = {6'b000000, 5'd1, 5'd10, 5'd9, 5'd0, 6'b100001};
    bus.M_AluRe   = 32'h0000_0007;
    #1;
    total++;
    if (bus.M_Pass !== 32'h0000_0007) begin
      bad++;
      $display("FAIL addu_pass: got %h want 00000007", bus.M_Pass);
    end
    total++;
    if (bus.M_rt !== 5'd10) begin
      bad++;
      $display("FAIL m_rt: got %h want 0a", bus.M_rt);
    end
    step();
  endtask

  task automatic test_wrap();
    drive(OP_SW, 32'h0000_1004, 32'hCAFE_F00D, 32'h0, 1'b0, 5'd0, 32'h0);
    step();
    load_chk("wrap", OP_LW, 32'h0000_0004, 32'hCAFE_F00D);
  endtask

  task automatic test_reset_priority();
    reset = 1'b0;
    drive(OP_SW, 32'h0000_0100, 32'h1234_5678, 32'h0, 1'b0, 5'd0, 32'h0);
    step();
    reset = 1'b1;
    load_chk("rst_prio", OP_LW, 32'h0000_0100, 32'h0);
    load_chk("rst_clear", OP_LW, 32'h0000_0008, 32'h0);
  endtask

  initial begin
    total = 0;
    bad   = 0;
    reset = 1'b0;
    drive(6'b000000, 32'h0, 32'h0, 32'h0, 1'b0, 5'd0, 32'h0);
    test_reset();
    test_sw_lw();
    test_lanes();
    test_forward();
    test_jal();
    test_wrap();
    test_reset_priority();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
